// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: round-robin Wishbone B3 RAM arbiter, grant 1 cycle after request, combinational data path, owner stalls on slave ack.
// Grant held for the whole cyc window; optional WB_RAM_ARB_TIMEOUT_EN errors a stalled owner and drains until it drops cyc.
module wb_ram_arbiter #(
  parameter int NUM_M          = 3,
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NUM_M*AW-1:0] m_adr_i,
  input  logic [NUM_M*32-1:0] m_dat_i,
  input  logic [NUM_M*4-1:0]  m_sel_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M-1:0]    m_cyc_i,
  input  logic [NUM_M-1:0]    m_stb_i,
  input  logic [NUM_M*3-1:0]  m_cti_i,
  output logic [NUM_M*32-1:0] m_dat_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [AW-1:0]       s_adr_o,
  output logic [31:0]         s_dat_o,
  output logic [3:0]          s_sel_o,
  output logic                s_we_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic [2:0]          s_cti_o,
  input  logic [31:0]         s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  output logic [NUM_M-1:0]    grant_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || NUM_M < 2) begin : g_bad_param
    $error("wb_ram_arbiter: TIMEOUT_CYCLES must be 2..65535 and NUM_M at least 2");
  end

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic [2:0]    cti;
  } wb_req_t;

`ifdef WB_RAM_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [NUM_M-1:0] grant, grant_nxt;
  logic [IW-1:0]    last, last_nxt;
  logic [IW-1:0]    win;
  logic             win_vld;
  logic             own_cyc, own_stb;
  wb_req_t          req_own;

  // Rotating priority: first requester strictly after the previous winner.
  always_comb begin
    int j;
    j       = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      j = (int'(last) + i) % NUM_M;
      if (!win_vld && m_cyc_i[IW'(j)]) begin
        win     = IW'(j);
        win_vld = 1'b1;
      end
    end
  end

  // The one-hot grant doubles as the mux select, so an idle bus routes zeros.
  always_comb begin
    req_own = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (grant[k]) begin
        req_own.adr = m_adr_i[k*AW +: AW];
        req_own.dat = m_dat_i[k*32 +: 32];
        req_own.sel = m_sel_i[k*4 +: 4];
        req_own.we  = m_we_i[k];
        req_own.cti = m_cti_i[k*3 +: 3];
      end
    end
  end

  assign own_cyc = |(grant & m_cyc_i);
  assign own_stb = |(grant & m_stb_i);

`ifdef WB_RAM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_hit;

  assign to_hit = (state == OWN) && (to_cnt == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_nxt != OWN || s_ack_i || s_err_i) begin
      to_cnt <= '0;
    end else if (s_stb_o) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m_ack_o   = '0;
    m_err_o   = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_nxt = NUM_M'(1) << win;
          last_nxt  = win;
          state_nxt = OWN;
        end
      end
      OWN: begin
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        m_ack_o = grant & {NUM_M{s_ack_i}};
        m_err_o = grant & {NUM_M{s_err_i}};
`ifdef WB_RAM_ARB_TIMEOUT_EN
        if (to_hit) begin
          s_cyc_o = 1'b0;
          s_stb_o = 1'b0;
          m_ack_o = '0;
          m_err_o = grant;
        end
`endif
        if (!own_cyc) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
`ifdef WB_RAM_ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_nxt = DRAIN;
        end
`endif
      end
`ifdef WB_RAM_ARB_TIMEOUT_EN
      DRAIN: begin
        if (!own_cyc) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
    // Reset silences the slave and the masters in the cycle it is asserted.
    if (wb_rst_i) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      m_ack_o = '0;
      m_err_o = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(NUM_M - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  assign s_adr_o = req_own.adr;
  assign s_dat_o = req_own.dat;
  assign s_sel_o = req_own.sel;
  assign s_we_o  = req_own.we;
  assign s_cti_o = req_own.cti;
  assign m_dat_o = {NUM_M{s_dat_i}};
  assign grant_o = grant;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: three master drivers, a latency-programmable RAM slave model and
// per-master read-data scoreboards; one task per scenario.
module tb_wb_ram_arbiter;

  localparam int NUM_M = 3;
  localparam int AW    = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_M*AW-1:0] m_adr;
  logic [NUM_M*32-1:0] m_dat;
  logic [NUM_M*4-1:0]  m_sel;
  logic [NUM_M-1:0]    m_we, m_cyc, m_stb;
  logic [NUM_M*3-1:0]  m_cti;
  logic [NUM_M*32-1:0] m_dat_o;
  logic [NUM_M-1:0]    m_ack_o, m_err_o, grant;
  logic [AW-1:0]       s_adr_o;
  logic [31:0]         s_dat_o, s_rdat;
  logic [3:0]          s_sel_o;
  logic                s_we_o, s_cyc_o, s_stb_o, s_ack, s_err;
  logic [2:0]          s_cti_o;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  wb_ram_arbiter #(.NUM_M(NUM_M), .AW(AW), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // RAM slave model: acks slv_lat cycles after seeing a strobe, never back-to-back.
  logic slv_en;
  int   slv_lat;
  int   slv_cnt;
  always @(posedge clk) begin
    if (rst) begin
      s_ack   <= 1'b0;
      s_rdat  <= '0;
      slv_cnt <= 0;
    end else begin
      s_ack <= 1'b0;
      if (slv_en && s_cyc_o && s_stb_o && !s_ack) begin
        if (slv_cnt >= slv_lat - 1) begin
          s_ack   <= 1'b1;
          s_rdat  <= rd_model(s_adr_o);
          slv_cnt <= 0;
        end else begin
          slv_cnt <= slv_cnt + 1;
        end
      end else begin
        slv_cnt <= 0;
      end
    end
  end

  task automatic push_exp(input int m, input logic [31:0] d);
    case (m)
      0:       exp_q0.push_back(d);
      1:       exp_q1.push_back(d);
      default: exp_q2.push_back(d);
    endcase
  endtask

  task automatic pop_exp(input int m, output logic [31:0] d, output bit ok);
    ok = 1'b1;
    d  = '0;
    case (m)
      0:       if (exp_q0.size() > 0) d = exp_q0.pop_front(); else ok = 1'b0;
      1:       if (exp_q1.size() > 0) d = exp_q1.pop_front(); else ok = 1'b0;
      default: if (exp_q2.size() > 0) d = exp_q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Master m reads `beats` words from base; each beat is scoreboarded on its ack.
  task automatic run_read(input int m, input logic [31:0] base, input int beats);
    int n;
    logic [31:0] d;
    bit ok;
    @(posedge clk); #1;
    m_we[m] = 1'b0;
    m_sel[m*4 +: 4] = 4'hF;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      m_adr[m*AW +: AW] = base + 32'(4 * b);
      m_cti[m*3 +: 3] = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
      push_exp(m, rd_model(base + 32'(4 * b)));
      n = 0;
      do begin @(negedge clk); n++; end while (m_ack_o[m] !== 1'b1 && n < 200);
      checks++;
      if (m_ack_o[m] !== 1'b1) begin
        errors++;
        $display("FAIL beat_ack m%0d beat %0d: ack=%b, required 1", m, b, m_ack_o[m]);
      end else begin
        pop_exp(m, d, ok);
        if (!ok || m_dat_o[m*32 +: 32] !== d) begin
          errors++;
          $display("FAIL read_data m%0d beat %0d: got %h, required %h", m, b, m_dat_o[m*32 +: 32], d);
        end
      end
      @(posedge clk); #1;
    end
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
    m_adr[m*AW +: AW] = '0;
    m_cti[m*3 +: 3] = '0;
  endtask

  task automatic test_reset();
    logic [2:0] exp_g[$];
    logic [2:0] e;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b, required 000", grant); end
    checks++;
    if ({s_cyc_o, s_stb_o} !== 2'b00) begin errors++; $display("FAIL reset_slave_ctl: got %b, required 00", {s_cyc_o, s_stb_o}); end
    checks++;
    if ({m_ack_o, m_err_o} !== 6'b0) begin errors++; $display("FAIL reset_resp: got %b, required 0", {m_ack_o, m_err_o}); end
    checks++;
    if ({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o} !== '0) begin
      errors++; $display("FAIL reset_idle_route: adr %h dat %h, required 0", s_adr_o, s_dat_o);
    end
    m_cyc = 3'b111;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_g = {3'b001, 3'b010, 3'b100};
    while (exp_g.size() > 0) begin
      e = exp_g.pop_front();
      n = 0;
      do begin @(negedge clk); n++; end while (grant === 3'b000 && n < 20);
      checks++;
      if (grant !== e) begin errors++; $display("FAIL rr_order: got %b, required %b", grant, e); end
      @(posedge clk); #1;
      m_cyc = m_cyc & ~e;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (grant !== 3'b000 || s_cyc_o !== 1'b0) begin
        errors++; $display("FAIL idle_gap: grant %b cyc %b, required 000/0", grant, s_cyc_o);
      end
    end
  endtask

  task automatic test_single_read();
    int n;
    bit other;
    logic [31:0] d;
    bit ok;
    other = 1'b0;
    slv_lat = 2;
    push_exp(1, 32'hDEADBEEF);
    @(posedge clk); #1;
    m_adr[AW +: AW] = 32'h100;
    m_cti[3 +: 3] = 3'b000;
    m_we[1] = 1'b0;
    m_sel[4 +: 4] = 4'hF;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if ((m_ack_o & 3'b101) !== 3'b000) other = 1'b1;
    end while (m_ack_o[1] !== 1'b1 && n < 20);
    checks++;
    if (m_ack_o !== 3'b010) begin errors++; $display("FAIL single_ack_vec: got %b, required 010", m_ack_o); end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL single_ack_latency: got %0d, required 4", n); end
    checks++;
    if (s_adr_o !== 32'h100) begin errors++; $display("FAIL single_adr: got %h, required 00000100", s_adr_o); end
    pop_exp(1, d, ok);
    checks++;
    if (!ok || m_dat_o[63:32] !== d) begin errors++; $display("FAIL single_data: got %h, required %h", m_dat_o[63:32], d); end
    checks++;
    if (other) begin errors++; $display("FAIL single_stray_ack: got 1, required 0"); end
    @(posedge clk); #1;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    m_adr[AW +: AW] = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 3'b000 || s_adr_o !== '0 || s_sel_o !== '0) begin
      errors++; $display("FAIL single_release: grant %b adr %h sel %h, required 0", grant, s_adr_o, s_sel_o);
    end
  endtask

  task automatic test_write_routing();
    int n;
    slv_lat = 1;
    @(posedge clk); #1;
    m_adr[2*AW +: AW] = 32'h44;
    m_dat[64 +: 32] = 32'hCAFEF00D;
    m_sel[8 +: 4] = 4'b0101;
    m_cti[6 +: 3] = 3'b111;
    m_we[2] = 1'b1;
    m_cyc[2] = 1'b1;
    m_stb[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (grant !== 3'b100 && n < 20);
    checks++;
    if ({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_cyc_o, s_stb_o} !==
        {32'h44, 32'hCAFEF00D, 4'b0101, 1'b1, 3'b111, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL write_route: adr %h dat %h sel %b we %b cti %b cyc %b stb %b, required 44 cafef00d 0101 1 111 1 1",
               s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_cyc_o, s_stb_o);
    end
    n = 0;
    while (m_ack_o === 3'b000 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (m_ack_o !== 3'b100 || m_err_o !== 3'b000) begin
      errors++; $display("FAIL write_ack: ack %b err %b, required 100 000", m_ack_o, m_err_o);
    end
    checks++;
    if (m_dat_o !== {3{rd_model(32'h44)}}) begin
      errors++; $display("FAIL dat_fanout: got %h, required %h in every slice", m_dat_o, rd_model(32'h44));
    end
    @(posedge clk); #1;
    m_cyc[2] = 1'b0;
    m_stb[2] = 1'b0;
    m_we[2] = 1'b0;
    m_adr[2*AW +: AW] = '0;
    m_cti[6 +: 3] = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o} !== '0) begin
      errors++; $display("FAIL write_idle_zero: adr %h dat %h we %b, required 0", s_adr_o, s_dat_o, s_we_o);
    end
  endtask

  task automatic test_burst_hold();
    int t0, g2_t, bad, n;
    bit burst_on;
    t0 = 0; g2_t = -1; bad = 0; burst_on = 1'b0;
    slv_lat = 1;
    fork
      begin
        burst_on = 1'b1;
        run_read(0, 32'h1000, 8);
        burst_on = 1'b0;
        t0 = cyc_cnt;
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (m_ack_o[0] !== 1'b1 && n < 50);
        run_read(2, 32'h2000, 1);
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (burst_on && grant !== 3'b000 && (grant !== 3'b001 || s_adr_o[31:12] !== 20'h1)) bad++;
          if (grant === 3'b100 && g2_t < 0) g2_t = cyc_cnt;
        end
      end
    join
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL burst_hold: %0d bad cycles, required 0", bad); end
    checks++;
    if (g2_t <= t0) begin errors++; $display("FAIL burst_handover: m2 grant at %0d, required after %0d", g2_t, t0); end
  endtask

  task automatic test_reset_mid_burst();
    int n, acks;
    acks = 0;
    slv_lat = 1;
    @(posedge clk); #1;
    m_adr[0 +: AW] = 32'h3000;
    m_cti[0 +: 3] = 3'b010;
    m_sel[0 +: 4] = 4'hF;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    n = 0;
    while (acks < 2 && n < 50) begin
      @(negedge clk); n++;
      if (m_ack_o[0] === 1'b1) acks++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_cyc_o, s_stb_o, m_ack_o} !== 5'b0) begin
      errors++; $display("FAIL rst_same_cycle: cyc %b stb %b ack %b, required 0", s_cyc_o, s_stb_o, m_ack_o);
    end
    @(negedge clk);
    checks++;
    if ({s_cyc_o, grant, m_ack_o} !== 7'b0) begin
      errors++; $display("FAIL rst_next_cycle: cyc %b grant %b ack %b, required 0", s_cyc_o, grant, m_ack_o);
    end
    m_cyc = 3'b011;
    m_stb = 3'b000;
    m_cti = '0;
    m_adr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (grant === 3'b000 && n < 20);
    checks++;
    if (grant !== 3'b001) begin errors++; $display("FAIL rst_first_winner: got %b, required 001", grant); end
    @(posedge clk); #1;
    m_cyc = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n, bad;
    bad = 0;
    slv_en = 1'b0;
    @(posedge clk); #1;
    m_adr[AW +: AW] = 32'h500;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
`ifdef WB_RAM_ARB_TIMEOUT_EN
    n = 0;
    do begin @(negedge clk); n++; end while (m_err_o === 3'b000 && n < 30);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL timeout_cycle: err at negedge %0d, required 6", n); end
    checks++;
    if (m_err_o !== 3'b010 || {s_cyc_o, s_stb_o} !== 2'b00) begin
      errors++; $display("FAIL timeout_err: err %b cyc %b stb %b, required 010 0 0", m_err_o, s_cyc_o, s_stb_o);
    end
    @(negedge clk);
    checks++;
    if (m_err_o !== 3'b000) begin errors++; $display("FAIL timeout_pulse: got %b, required 000", m_err_o); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_cyc_o !== 1'b0 || grant !== 3'b010) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL drain_hold: %0d bad cycles, required 0", bad); end
`else
    n = 0;
    do begin @(negedge clk); n++; end while (grant !== 3'b010 && n < 20);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_cyc_o !== 1'b1 || m_err_o !== 3'b000) bad++;
    end
    checks++;
    if (grant !== 3'b010) begin errors++; $display("FAIL wait_grant: got %b, required 010", grant); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wait_forever: %0d bad cycles, required 0", bad); end
`endif
    @(posedge clk); #1;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    m_adr[AW +: AW] = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 3'b000 || s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL stall_release: grant %b cyc %b, required 000 0", grant, s_cyc_o);
    end
    slv_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
    m_cyc = '0; m_stb = '0; m_cti = '0;
    s_err = 1'b0;
    slv_en = 1'b1;
    slv_lat = 1;
    test_reset();
    test_single_read();
    test_write_routing();
    test_burst_hold();
    test_reset_mid_burst();
    test_timeout();
    checks++;
    if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

Round-robin Wishbone B3 arbiter that shares the single system RAM slave (`wb_bfm_memory` in `orpsoc_top`) between `NUM_M` masters: CPU instruction bus, CPU data bus and the debug-unit bus. It holds a grant for the whole `cyc` window, including CTI incrementing bursts, so that the CPU caches' refills are never interleaved. It sits between the masters and the RAM slave in `orpsoc_top`, and is clocked by the system Wishbone clock.

## Interface
- `NUM_M`, 3, number of masters; index 0 = ibus, 1 = dbus, 2 = debug.
- `AW`, 32, address width; data width is fixed at 32.
- `TIMEOUT_CYCLES`, 255, stall cycles before a bus error is returned; used only when `WB_RAM_ARB_TIMEOUT_EN` is defined, range 2..65535.
- `wb_clk_i`  in  1  system clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `m_adr_i`  in  NUM_M*AW  master addresses; master k occupies slice k.
- `m_dat_i`  in  NUM_M*32  master write data.
- `m_sel_i`  in  NUM_M*4  byte selects.
- `m_we_i`  in  NUM_M  write enables.
- `m_cyc_i`  in  NUM_M  cycle requests.
- `m_stb_i`  in  NUM_M  strobes.
- `m_cti_i`  in  NUM_M*3  cycle type identifiers.
- `m_dat_o`  out  NUM_M*32  read data; every slice is driven with `s_dat_i`.
- `m_ack_o`  out  NUM_M  acknowledge, owner only.
- `m_err_o`  out  NUM_M  error, owner only.
- `s_adr_o`  out  AW  slave address.
- `s_dat_o`  out  32  slave write data.
- `s_sel_o`  out  4  slave byte selects.
- `s_we_o`  out  1  slave write enable.
- `s_cyc_o`  out  1  slave cycle.
- `s_stb_o`  out  1  slave strobe.
- `s_cti_o`  out  3  slave cycle type.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`  in  1  slave acknowledge.
- `s_err_i`  in  1  slave error.
- `grant_o`  out  NUM_M  registered one-hot owner; all zero when the bus is idle.

## Operation
- **States.** The arbiter has three states: IDLE, OWN and DRAIN (DRAIN exists only when timeout is compiled in).
- **IDLE.** When any `m_cyc_i` bit is set, pick the first requester scanning upward from `last+1`, wrapping modulo `NUM_M`. Register `grant_o` and set `last` to the winner. Go to OWN.
- **OWN, routing.** Route the owner's `adr`, `dat`, `sel`, `we` and `cti` to the slave.
- **OWN, control gating.** `s_cyc_o = m_cyc_i[own]` and `s_stb_o = m_stb_i[own]`, both combinational and both gated by the state.
- **OWN, responses.** `m_ack_o[own] = s_ack_i` and `m_err_o[own] = s_err_i`. All other ack and err bits are 0.
- **OWN, release.** When `m_cyc_i[own]` falls, clear `grant_o` and return to IDLE. Releasing in the middle of a burst is legal.
- **Bursts.** Bursts need no special handling. The grant is held for as long as `cyc` is high, whatever `cti` says.
- **Simultaneous requests.** Strict rotation applies. Example: after master 1 is served, the order among pending masters is 2, 0, 1.
- **Reset.** Reset, including reset in the middle of a transfer, forces IDLE, `grant_o = 0` and `last = NUM_M-1` (so master 0 wins first). All `s_cyc_o`, `s_stb_o`, `m_ack_o` and `m_err_o` go to 0 in the same cycle.
- **Unselected slave outputs.** When no master owns the bus, `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o` and `s_cti_o` are 0.

## Timing
- **Arbitration latency.** 1 cycle. A request seen at edge N gives `grant_o` and `s_cyc_o` after edge N.
- **Data path.** Combinational, 0 cycles. Ack latency equals the slave's ack latency.
- **Turnaround.** At least 1 idle cycle between owners, because the release goes through IDLE.
- **Back-to-back requests.** A master that drops `cyc` and raises it again the next cycle competes again. It loses to any other pending master.

## Configuration
- **With `WB_RAM_ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter increments on each cycle where `s_stb_o` is 1 and neither `s_ack_i` nor `s_err_i` is 1. It clears on ack, on err and when leaving OWN.
  - When the counter reaches `TIMEOUT_CYCLES`, the owner sees `m_err_o` high for exactly 1 cycle. In that cycle `s_cyc_o` and `s_stb_o` are forced to 0.
  - The arbiter then enters DRAIN and holds the slave inactive until the owner drops `cyc`, then returns to IDLE.
- **Without the macro:** there is no counter and no DRAIN state, and the arbiter waits indefinitely for the slave.

## Test plan
- **Reset default:** hold reset, then raise all three `m_cyc_i` at once → `grant_o` sequence 001, 010, 100, each grant separated by one idle cycle.
- **Single read:** master 1 reads `0x100` while the slave acks after 2 cycles with `0xDEADBEEF` → `m_ack_o = 010` and `m_dat_o` slice 1 = `0xDEADBEEF`. No ack appears on masters 0 or 2.
- **Burst hold:** master 0 runs an 8-beat `cti = 010` burst while master 2 requests from its second beat → master 2 is granted only after master 0's `cti = 111` beat and the fall of `cyc`. `s_adr_o` never switches to master 2's address during the burst.
- **Reset mid-burst:** assert reset during beat 3 of a burst → the next cycle shows `s_cyc_o = 0`, `grant_o = 0` and `m_ack_o = 0`. After reset, master 0 is served first.
- **Timeout (macro on):** with `TIMEOUT_CYCLES = 4` and a slave that never acks → `m_err_o[1]` pulses for one cycle after the 4th stall cycle. `s_cyc_o` stays 0 until master 1 drops `cyc`. With the macro off, the same stimulus leaves `s_cyc_o` high indefinitely.
